leaf_inject_sched: RTL
======================

Name: leaf_inject_sched

Overview:
- Injection scheduler at a BFT leaf.
- Shares one leaf-side input bus of a t_switch (l_bus_i or r_bus_i) among num_req local requesters.
- Forms packets {valid, dest_addr, payload} with round-robin fairness and a token-window injection throttle, so a leaf cannot saturate the tree.
- Self-addressed packets are dropped and counted.

Parameters:
- num_leaves, 2, leaves in the tree; address width A = $clog2(num_leaves).
- payload_sz, 1, payload bits per packet.
- addr, 0, this leaf's own address.
- num_req, 4, number of local requesters (>=2).
- window, 16, throttle window length in cycles (>=2).
- max_burst, 8, packets allowed per window (1..window).
- p_sz, 1+A+payload_sz, packet width; derived, not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  num_req  per-requester packet valid
- req_ready  out  num_req  per-requester accept (one-hot or zero)
- req_addr  in  num_req*A  destination address; requester i occupies [i*A +: A]
- req_payload  in  num_req*payload_sz  payload; requester i occupies [i*payload_sz +: payload_sz]
- throttle_en  in  1  1 = enforce token window; 0 = unlimited injection
- bus_o  out  p_sz  packet to the t_switch leaf input; MSB is valid
- grant_id  out  $clog2(num_req)  index of the requester emitted on bus_o (valid when bus_o[p_sz-1])
- drop_cnt  out  16  saturating count of self-addressed packets dropped

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: bus_o=0, grant_id=0, drop_cnt=0, rr pointer=0, tokens=max_burst, window counter=0.
- Grant (combinational from registered state):
  - Search req_valid starting at rr pointer, wrapping modulo num_req.
  - The first set bit wins; req_ready has that bit only.
  - req_ready is all-zero when:
    - no valid requester, or
    - throttle_en=1, tokens=0, and the winner is not self-addressed.
  - req_ready never depends combinationally on req_addr of non-winning requesters.
- Transfer: occurs when req_valid[i] & req_ready[i].
  - Requesters hold valid, addr and payload stable until accepted.
- Pointer: after a transfer from i, rr pointer <= (i+1) mod num_req. Otherwise unchanged.
- Output latency: 1 cycle, registered.
  - On a transfer of a non-self packet: bus_o <= {1'b1, req_addr[i], req_payload[i]}, grant_id <= i.
  - Otherwise bus_o <= 0 and grant_id holds its previous value.
  - One packet at most per cycle.
- Self-addressed (req_addr[i]==addr):
  - Accepted normally (ready asserted even when tokens=0) and the pointer advances.
  - bus_o <= 0; consumes no token.
  - drop_cnt <= drop_cnt+1, saturating at 16'hFFFF.
- Window counter: counts 0..window-1 and wraps to 0 every cycle regardless of traffic.
- Tokens:
  - Width covers 0..max_burst.
  - Decrement by 1 per emitted (non-self) packet when throttle_en=1.
  - On the cycle the counter equals window-1: tokens <= max_burst - (emit & throttle_en); reload wins over plain decrement.
  - tokens never underflow.
  - When throttle_en=0, tokens are not decremented but still reload.
- throttle_en toggling takes effect in the same cycle for grant gating; no state is flushed.
- Reset asserted mid-operation:
  - All state returns to reset values next edge; req_ready is forced 0 during reset.
  - An in-flight bus_o packet is discarded (bus_o=0).

Decomposition:
- Shared package/header:
  - Packet field offsets (valid bit = p_sz-1, addr field [p_sz-2:payload_sz], payload [payload_sz-1:0]).
  - clog2-derived width constants, so leaf_inject_sched, t_switch and direction_determiner agree on the packet layout.
- One sub-module: rr_arbiter. Parameterized num_req; inputs req vector, pointer and enable; outputs one-hot grant and encoded index. Purely combinational; pointer register lives in the parent.

Test Plan:
- Single requester (num_req=4, num_leaves=4, addr=0):
  - Stimulus: req_valid=0001, req_addr[0]=2, payload=1, throttle_en=0.
  - Response: req_ready=0001 same cycle; next cycle bus_o={1,2'b10,1'b1}, grant_id=0.
- Round-robin fairness:
  - Stimulus: all four valid continuously with non-self addresses, throttle_en=0.
  - Response: grant_id sequence 0,1,2,3,0,1 on consecutive cycles; no idle cycles.
- Throttle (window=16, max_burst=8, throttle_en=1, all valid from reset):
  - Response: bus_o valid for cycles 1..8 after reset, then zero until window wrap; tokens reload to 8 at counter=15.
  - Exactly 8 packets per 16-cycle window thereafter.
- Self-addressed with tokens=0:
  - Stimulus: requester 2 valid with req_addr=addr.
  - Response: req_ready[2]=1, bus_o stays 0, drop_cnt increments by 1, tokens unchanged; drop_cnt saturates at 16'hFFFF after forced preload.
- Reset mid-burst:
  - Stimulus: assert reset for 1 cycle while bus_o is valid.
  - Response: next edge bus_o=0, drop_cnt=0, tokens=8.
  - The first grant after release goes to requester 0 even if the pointer was 3.

Source files
------------

// File: rtl/leaf_inject_sched_pkg.sv
// Shared packet-layout helpers for the BFT leaf, t_switch and direction_determiner.
// Every block derives its field widths and offsets from these functions so the layouts stay in step.
package leaf_inject_sched_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  function automatic int unsigned addr_width(input int unsigned leaves);
    return (leaves > 1) ? $clog2(leaves) : 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Packet layout, MSB first: {valid, dest_addr, payload}
  function automatic int unsigned pkt_width(input int unsigned leaves, input int unsigned payload);
    return 1 + addr_width(leaves) + payload;
  endfunction

  function automatic int unsigned pkt_valid_bit(input int unsigned p_sz);
    return p_sz - 1;
  endfunction

  function automatic int unsigned pkt_addr_lsb(input int unsigned payload);
    return payload;
  endfunction

endpackage

// File: rtl/leaf_inject_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins.
// The pointer register lives in the parent; enable only gates the one-hot grant.
module rr_arbiter
  import leaf_inject_sched_pkg::*;
#(
  parameter int unsigned num_req = 4,
  localparam int unsigned IW = idx_width(num_req)
) (
  input  logic [num_req-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               enable,
  output logic [num_req-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               found
);

  localparam int N = int'(num_req);

  logic [num_req-1:0] onehot;

  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  always_comb begin
    logic [IW-1:0] j;
    onehot    = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found     = 1'b1;
        grant_idx = j;
        onehot[j] = 1'b1;
      end
    end
  end

  // Gating kept outside the search so enable (which depends on grant_idx) forms no loop.
  assign grant = enable ? onehot : '0;

endmodule

// File: rtl/leaf_inject_sched.sv
// Injection scheduler at a BFT leaf: round-robin sharing of one t_switch leaf input,
// token-window throttling, and dropping/counting of self-addressed packets.
module leaf_inject_sched
  import leaf_inject_sched_pkg::*;
#(
  parameter int unsigned num_leaves = 2,
  parameter int unsigned payload_sz = 1,
  parameter int unsigned addr       = 0,
  parameter int unsigned num_req    = 4,
  parameter int unsigned window     = 16,
  parameter int unsigned max_burst  = 8,
  localparam int unsigned A    = addr_width(num_leaves),
  localparam int unsigned p_sz = pkt_width(num_leaves, payload_sz),
  localparam int unsigned IW   = idx_width(num_req)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [num_req-1:0]            req_valid,
  output logic [num_req-1:0]            req_ready,
  input  logic [num_req*A-1:0]          req_addr,
  input  logic [num_req*payload_sz-1:0] req_payload,
  input  logic                          throttle_en,
  output logic [p_sz-1:0]               bus_o,
  output logic [IW-1:0]                 grant_id,
  output logic [DROP_CNT_W-1:0]         drop_cnt
);

  localparam int unsigned TW = $clog2(max_burst + 1);
  localparam int unsigned WW = $clog2(window);

  localparam logic [TW-1:0]         TOK_FULL = TW'(max_burst);
  localparam logic [WW-1:0]         WIN_LAST = WW'(window - 1);
  localparam logic [IW-1:0]         REQ_LAST = IW'(num_req - 1);
  localparam logic [A-1:0]          OWN_ADDR = A'(addr);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  logic [IW-1:0] ptr_q;
  logic [TW-1:0] tokens_q;
  logic [WW-1:0] wcnt_q;

  logic [IW-1:0]         win_idx;
  logic                  win_found;
  logic [A-1:0]          win_addr;
  logic [payload_sz-1:0] win_pay;
  logic                  win_self;
  logic                  arb_en;
  logic                  xfer;
  logic                  emit;
  logic                  drop;
  logic                  spend;

  rr_arbiter #(.num_req(num_req)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .enable    (arb_en),
    .grant     (req_ready),
    .grant_idx (win_idx),
    .found     (win_found)
  );

  // Only the winner's address is inspected, so losers never affect req_ready.
  assign win_addr = req_addr[win_idx*A +: A];
  assign win_pay  = req_payload[win_idx*payload_sz +: payload_sz];
  assign win_self = (win_addr == OWN_ADDR);

  // Self-addressed packets bypass the token gate: they never reach the tree.
  assign arb_en = !reset && win_found && !(throttle_en && (tokens_q == '0) && !win_self);
  assign xfer   = arb_en;
  assign emit   = xfer && !win_self;
  assign drop   = xfer && win_self;
  assign spend  = emit && throttle_en;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      tokens_q <= TOK_FULL;
      wcnt_q   <= '0;
      bus_o    <= '0;
      grant_id <= '0;
      drop_cnt <= '0;
    end else begin
      wcnt_q <= (wcnt_q == WIN_LAST) ? '0 : wcnt_q + 1'b1;

      // Reload wins over a same-cycle spend; the spend is charged to the new window.
      if (wcnt_q == WIN_LAST) begin
        tokens_q <= TOK_FULL - TW'(spend);
      end else if (spend) begin
        tokens_q <= tokens_q - 1'b1;
      end

      if (xfer) begin
        ptr_q <= (win_idx == REQ_LAST) ? '0 : win_idx + 1'b1;
      end

      if (emit) begin
        bus_o    <= {1'b1, win_addr, win_pay};
        grant_id <= win_idx;
      end else begin
        bus_o <= '0;
      end

      if (drop && (drop_cnt != DROP_MAX)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule
